// File: rtl/sd_spi_responder_if.sv
// Command/response handshake between the SPI responder and the card-model logic.
// The responder uses the slave modport; the card model drives the master side.
interface sd_spi_responder_if;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        rsp_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        ncr_timeout;

  modport slave (
    output cmd_valid, cmd_index, cmd_arg, rsp_ready, ncr_timeout,
    input  rsp_valid, rsp_data
  );

  modport master (
    input  cmd_valid, cmd_index, cmd_arg, rsp_ready, ncr_timeout,
    output rsp_valid, rsp_data
  );
endinterface

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card responder: oversamples the SPI pins, deframes 48-bit commands, returns R1.
// Optional macro SD_SPI_CRC7_CHECK_EN enables CRC7 checking of the command frame (R1=0x08 on error).
module sd_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int NCR_MAX     = 8
) (
  input  logic              sys_clk,
  input  logic              sys_reset,
  input  logic              sd_clk,
  input  logic              sd_cs,
  input  logic              sd_mosi,
  output logic              sd_miso,
  sd_spi_responder_if.slave rsp_bus
);

  typedef enum logic [2:0] {
    IDLE,
    HUNT,
    CMD_RX,
    WAIT_RSP,
    RSP_TX
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] clk_sync, cs_sync, mosi_sync;
  logic       clk_prev;
  logic       clk_s, cs_s, mosi_s, rise, fall;

  // cmd_sr keeps frame bits 46..1 once the final bit arrives; bit 47 is always 0.
  logic [45:0] cmd_sr;
  logic [5:0]  bit_cnt;
  logic [2:0]  byte_bit;
  logic [7:0]  fill_cnt, fill_next;
  logic [7:0]  miso_sr;
  logic        pend_valid;
  logic [7:0]  pend_data;

  logic        frame_done, frame_ok, load_byte, send_pending, timeout_hit, rsp_accept;
  logic [7:0]  err_code;

`ifdef SD_SPI_CRC7_CHECK_EN
  logic [6:0] crc;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      clk_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '1;
      clk_prev  <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], sd_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], sd_cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], sd_mosi};
      clk_prev  <= clk_s;
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign rise   = clk_s & ~clk_prev;
  assign fall   = ~clk_s & clk_prev;

  assign sd_miso           = miso_sr[7];
  assign rsp_bus.rsp_ready = (state == WAIT_RSP) && !pend_valid;
  assign rsp_accept        = rsp_bus.rsp_ready && rsp_bus.rsp_valid && !cs_s;
  assign fill_next         = fill_cnt + 8'd1;
  // The first byte after a frame (fill_cnt==0) is always a fill byte.
  assign send_pending      = pend_valid && (fill_cnt != 8'd0);

  always_comb begin
    frame_ok = cmd_sr[45] & mosi_s;
    err_code = 8'h04;
`ifdef SD_SPI_CRC7_CHECK_EN
    if (frame_ok && (cmd_sr[6:0] != crc)) begin
      frame_ok = 1'b0;
      err_code = 8'h08;
    end
`endif
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next  = state;
    frame_done  = 1'b0;
    load_byte   = 1'b0;
    timeout_hit = 1'b0;
    if (cs_s) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:     state_next = HUNT;
        HUNT:     if (rise && !mosi_s) state_next = CMD_RX;
        CMD_RX: begin
          if (rise && bit_cnt == 6'd47) begin
            frame_done = 1'b1;
            state_next = WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (fall && byte_bit == 3'd0) begin
            load_byte = 1'b1;
            if (send_pending) begin
              state_next = RSP_TX;
            end else if (fill_next == 8'(NCR_MAX)) begin
              timeout_hit = 1'b1;
              state_next  = RSP_TX;
            end
          end
        end
        RSP_TX:   if (rise && byte_bit == 3'd7) state_next = HUNT;
        default:  state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      cmd_sr              <= '0;
      bit_cnt             <= '0;
      byte_bit            <= '0;
      fill_cnt            <= '0;
      miso_sr             <= 8'hFF;
      pend_valid          <= 1'b0;
      pend_data           <= '0;
      rsp_bus.cmd_valid   <= 1'b0;
      rsp_bus.cmd_index   <= '0;
      rsp_bus.cmd_arg     <= '0;
      rsp_bus.ncr_timeout <= 1'b0;
`ifdef SD_SPI_CRC7_CHECK_EN
      crc                 <= '0;
`endif
    end else begin
      rsp_bus.cmd_valid   <= 1'b0;
      rsp_bus.ncr_timeout <= 1'b0;
      if (cs_s) begin
        bit_cnt    <= '0;
        byte_bit   <= '0;
        fill_cnt   <= '0;
        miso_sr    <= 8'hFF;
        pend_valid <= 1'b0;
      end else begin
        if (rise) byte_bit <= byte_bit + 3'd1;
        case (state)
          HUNT: begin
            if (rise && !mosi_s) begin
              cmd_sr  <= {45'd0, mosi_s};
              bit_cnt <= 6'd1;
`ifdef SD_SPI_CRC7_CHECK_EN
              crc     <= '0;
`endif
            end
          end
          CMD_RX: begin
            if (rise) begin
              cmd_sr  <= {cmd_sr[44:0], mosi_s};
              bit_cnt <= bit_cnt + 6'd1;
`ifdef SD_SPI_CRC7_CHECK_EN
              if (bit_cnt <= 6'd39) crc <= crc7_step(crc, mosi_s);
`endif
            end
            if (frame_done) begin
              byte_bit <= '0;
              fill_cnt <= '0;
              if (frame_ok) begin
                rsp_bus.cmd_valid <= 1'b1;
                rsp_bus.cmd_index <= cmd_sr[44:39];
                rsp_bus.cmd_arg   <= cmd_sr[38:7];
                pend_valid        <= 1'b0;
              end else begin
                pend_valid <= 1'b1;
                pend_data  <= err_code;
              end
            end
          end
          WAIT_RSP: begin
            if (load_byte) begin
              if (send_pending) begin
                miso_sr    <= pend_data;
                pend_valid <= 1'b0;
              end else begin
                miso_sr  <= 8'hFF;
                fill_cnt <= fill_next;
              end
              if (timeout_hit) rsp_bus.ncr_timeout <= 1'b1;
            end else if (fall) begin
              miso_sr <= {miso_sr[6:0], 1'b1};
            end
            // An accept coinciding with a load lands after it, so it waits for the next boundary.
            if (rsp_accept) begin
              pend_valid <= 1'b1;
              pend_data  <= rsp_bus.rsp_data;
            end
          end
          RSP_TX: begin
            if (fall) miso_sr <= {miso_sr[6:0], 1'b1};
          end
          default: ;
        endcase
        if (state_next == HUNT) begin
          miso_sr    <= 8'hFF;
          pend_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/sd_spi_responder.md
Name: sd_spi_responder

Overview:
- SPI-mode SD-card responder: the card end of the SD link that TOP drives through sd_clk/sd_cs/sd_mosi/sd_miso.
- Oversamples the SPI pins in the sys_clk domain, deframes 48-bit commands and hands them to card-model logic.
- Returns the R1 byte supplied by that logic on sd_miso.
- Used in simulation benches and FPGA loopback builds to exercise the SD master without a physical card.

Parameters:
SYNC_STAGES, 2, synchronizer depth on sd_clk/sd_cs/sd_mosi (≥2)
NCR_MAX, 8, max 0xFF fill bytes sent while waiting for a response before timeout (1..255)

Ports:
sys_clk  in  1  system clock; must be ≥8× sd_clk frequency
sys_reset  in  1  synchronous, active-high reset
sd_clk  in  1  SPI clock from master, mode 0, asynchronous
sd_cs  in  1  chip select, active low
sd_mosi  in  1  command data from master
sd_miso  out  1  response data to master
cmd_valid  out  1  one-cycle pulse: a good command frame was received
cmd_index  out  6  command index (frame bits 45:40), held until next cmd_valid
cmd_arg  out  32  argument (frame bits 39:8), held until next cmd_valid
rsp_ready  out  1  responder can accept an R1 byte
rsp_valid  in  1  R1 byte offered
rsp_data  in  8  R1 byte, sent MSB first as-is
ncr_timeout  out  1  one-cycle pulse: NCR_MAX fill bytes sent with no response

Behaviour:
- Reset: sd_miso=1, cmd_valid=0, cmd_index=0, cmd_arg=0, rsp_ready=0, ncr_timeout=0; state IDLE; all counters 0.
- Sync: inputs pass through SYNC_STAGES flops. Edges are detected on the synchronized sd_clk. A rise samples MOSI; a fall updates MISO.
- States:
  - IDLE: entered while sd_cs=1. Leaves for HUNT when sd_cs=0.
  - HUNT: on each rise with MOSI=0, begin the frame (that bit is bit 47, bit counter=1) and go to CMD_RX. sd_miso=1.
  - CMD_RX: shift 48 bits MSB-first. After the 48th rise, check bit46=1 and bit0=1.
    - Pass: load cmd_index/cmd_arg, pulse cmd_valid on the next sys_clk, go to WAIT_RSP.
    - Fail: no cmd_valid; internally latch R1=0x04 (illegal command) as the pending response, then go to WAIT_RSP.
  - WAIT_RSP: rsp_ready=1 until a byte is accepted (rsp_valid&&rsp_ready); the accepted byte becomes pending.
    - Byte boundaries count from the frame start. On the first fall of each byte, load the MISO shifter.
    - Load rule: fill byte 0 is always 0xFF (Ncr≥1), even if a response is already pending. Later bytes load the pending byte if present, else 0xFF and the fill counter increments.
    - When the pending byte is loaded, go to RSP_TX and drop rsp_ready.
    - If the fill counter reaches NCR_MAX with nothing pending: pulse ncr_timeout, drop rsp_ready, return to HUNT after that byte; a later rsp_valid is ignored.
  - RSP_TX: shift out the 8 bits on falls. After the 8th bit's fall-to-rise completes, go to HUNT and set sd_miso=1.
- Non-load falls shift MSB-first. sd_miso is stable across each rise.
- sd_cs deassert (synced) in any state: go to IDLE next cycle, sd_miso=1, rsp_ready=0, and discard the pending byte and counters. A cmd_valid already issued is not retracted.
- sys_reset mid-frame: full reset as above; the partial frame is lost.
- rsp_valid outside WAIT_RSP is ignored (rsp_ready=0).
- Simultaneous rsp accept and a byte-load fall in the same cycle: the byte takes effect at the next boundary, not the current one.
- Back-to-back commands: HUNT resumes immediately after RSP_TX; a 0 bit in the very next byte starts a new frame.

Optional Feature:
SD_SPI_CRC7_CHECK_EN
- Defined: CRC7 (poly x^7+x^3+1, init 0) is computed over frame bits 47:8 and compared to bits 7:1. On a mismatch with valid framing, no cmd_valid is issued; pending R1=0x08 (COM CRC error) is sent through the normal WAIT_RSP path. A framing error still takes priority and yields 0x04.
- Not defined: bits 7:1 are ignored and no CRC logic is built.

Test Plan:
- CMD0 frame 40 00 00 00 00 95 at sd_clk=sys_clk/10, rsp 0x01 offered 3 cycles after cmd_valid -> cmd_valid=1 once, cmd_index=0, cmd_arg=0; MISO bytes FF,01 then FF.
- CMD17 frame 51 00 00 12 34 55, rsp held off until 4 bytes clocked -> cmd_index=17, cmd_arg=0x00001234; MISO bytes FF,FF,FF,FF,R1.
- Command with no response, NCR_MAX=8 -> 8 FF bytes, ncr_timeout pulse, a rsp_valid after the timeout is ignored, sd_miso=1.
- Frame 40 00 00 00 00 94 (end bit 0) -> no cmd_valid; MISO FF,04.
- sd_cs raised after 20 bits of a frame, then a new CMD0 -> first frame dropped with no cmd_valid; second decodes normally.
- With SD_SPI_CRC7_CHECK_EN, frame 40 00 00 00 00 97 -> no cmd_valid; MISO FF,08; the 0x95 variant passes.
